// File: rtl/tri_scan_driver_pkg.sv
// Shared types and constants for the triangle scan driver and its sign collector.
package tri_scan_pkg;

  localparam int unsigned CoordW = 11;
  localparam int unsigned PhLast = 2;

  typedef logic [CoordW-1:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StTrst,
    StLd0,
    StLd1,
    StLd2,
    StFeed,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/tri_scan_driver_if.sv
// Control-side and tester-side signal bundle of the triangle scan driver.
interface tri_scan_if
  import tri_scan_pkg::*;
#(
  parameter int unsigned W = CoordW
) ();

  logic         start;
  logic [W-1:0] ax, ay, bx, by, cx, cy;
  logic         busy;
  logic         t_r;
  logic         t_re;
  logic [W-1:0] t_i1, t_i2;
  logic         t_s;
  logic         p_valid;
  logic [W-1:0] px, py;
  logic         p_in;
  logic         done;

  modport master (
    input  start, ax, ay, bx, by, cx, cy, t_s,
    output busy, t_r, t_re, t_i1, t_i2, p_valid, px, py, p_in, done
  );

  modport slave (
    output start, ax, ay, bx, by, cx, cy, t_s,
    input  busy, t_r, t_re, t_i1, t_i2, p_valid, px, py, p_in, done
  );

endinterface

// File: rtl/tri_scan_driver_sign_collector.sv
// Delays each point strobe by the tester latency, gathers its three edge-sign bits
// and reports one inside/outside verdict with the point's coordinates.
module sign_collector #(
  parameter int unsigned W        = 11,
  parameter int unsigned SIGN_LAT = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         strobe_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         t_s_i,
  output logic         p_valid_o,
  output logic [W-1:0] px_o,
  output logic [W-1:0] py_o,
  output logic         p_in_o
);

  logic [SIGN_LAT-1:0] stb_q;
  logic [W-1:0]        dx_q [SIGN_LAT];
  logic [W-1:0]        dy_q [SIGN_LAT];

  logic [1:0]   cnt_q, cnt_d;
  logic [2:0]   sh_q, sh_d;
  logic [W-1:0] lx_q, lx_d, ly_q, ly_d;
  logic         p_valid_q, p_valid_d;
  logic [W-1:0] px_q, px_d, py_q, py_d;
  logic         p_in_q, p_in_d;
  logic         exit_stb;

  assign exit_stb = stb_q[SIGN_LAT-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q <= '0;
      for (int i = 0; i < SIGN_LAT; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
    end else begin
      stb_q[0] <= strobe_i;
      dx_q[0]  <= x_i;
      dy_q[0]  <= y_i;
      for (int i = 1; i < SIGN_LAT; i++) begin
        stb_q[i] <= stb_q[i-1];
        dx_q[i]  <= dx_q[i-1];
        dy_q[i]  <= dy_q[i-1];
      end
    end
  end

  // cnt_q: 0 = waiting for a strobe, 1/2 = e0 already held, sampling e1/e2.
  always_comb begin
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    lx_d      = lx_q;
    ly_d      = ly_q;
    p_valid_d = 1'b0;
    px_d      = px_q;
    py_d      = py_q;
    p_in_d    = p_in_q;
    unique case (cnt_q)
      2'd0: begin
        if (exit_stb) begin
          sh_d  = {sh_q[1:0], t_s_i};
          lx_d  = dx_q[SIGN_LAT-1];
          ly_d  = dy_q[SIGN_LAT-1];
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        sh_d  = {sh_q[1:0], t_s_i};
        cnt_d = 2'd2;
      end
      2'd2: begin
        sh_d      = {sh_q[1:0], t_s_i};
        cnt_d     = 2'd0;
        p_valid_d = 1'b1;
        px_d      = lx_q;
        py_d      = ly_q;
        p_in_d    = (sh_q[1] == sh_q[0]) && (sh_q[0] == t_s_i);
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= 2'd0;
      sh_q      <= 3'd0;
      lx_q      <= '0;
      ly_q      <= '0;
      p_valid_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      p_in_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      p_valid_q <= p_valid_d;
      px_q      <= px_d;
      py_q      <= py_d;
      p_in_q    <= p_in_d;
    end
  end

  assign p_valid_o = p_valid_q;
  assign px_o      = px_q;
  assign py_o      = py_q;
  assign p_in_o    = p_in_q;

endmodule

// File: rtl/tri_scan_driver.sv
// Host-side driver for the point-in-triangle sign tester: loads the vertices, raster-scans
// the bounding box one point per three cycles and reports a verdict per pixel.
module tri_scan_driver
  import tri_scan_pkg::*;
#(
  parameter int unsigned W        = CoordW,
  parameter int unsigned SIGN_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  tri_scan_if.master bus
);

  localparam int unsigned DrainLast = SIGN_LAT + 2;
  localparam int unsigned DrainW    = $clog2(DrainLast + 1);

  state_e state_q, state_d;

  logic [W-1:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d, cx_q, cx_d, cy_q, cy_d;
  logic [W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]   ph_q, ph_d;
  logic [DrainW-1:0] dcnt_q, dcnt_d;

  logic         busy_q, busy_d;
  logic         t_r_q, t_r_d;
  logic         t_re_q, t_re_d;
  logic [W-1:0] t_i1_q, t_i1_d, t_i2_q, t_i2_d;
  logic         done_q, done_d;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    state_d = state_q;
    ax_d = ax_q; ay_d = ay_q; bx_d = bx_q; by_d = by_q; cx_d = cx_q; cy_d = cy_q;
    xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
    x_d    = x_q;
    y_d    = y_q;
    ph_d   = ph_q;
    dcnt_d = dcnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ax_d = bus.ax; ay_d = bus.ay; bx_d = bus.bx;
          by_d = bus.by; cx_d = bus.cx; cy_d = bus.cy;
          xmin_d  = min3(bus.ax, bus.bx, bus.cx);
          xmax_d  = max3(bus.ax, bus.bx, bus.cx);
          ymin_d  = min3(bus.ay, bus.by, bus.cy);
          ymax_d  = max3(bus.ay, bus.by, bus.cy);
          state_d = StTrst;
        end
      end
      StTrst: state_d = StLd0;
      StLd0:  state_d = StLd1;
      StLd1:  state_d = StLd2;
      StLd2: begin
        state_d = StFeed;
        x_d     = xmin_q;
        y_d     = ymin_q;
        ph_d    = 2'd0;
      end
      StFeed: begin
        if (ph_q == 2'(PhLast)) begin
          ph_d = 2'd0;
          // Compare before increment so xmax = all-ones never wraps the cursor.
          if (x_q == xmax_q) begin
            x_d = xmin_q;
            if (y_q == ymax_q) begin
              state_d = StDrain;
              dcnt_d  = '0;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      StDrain: begin
        if (dcnt_q == DrainW'(DrainLast)) begin
          state_d = StDone;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d = (state_d != StIdle);
    t_r_d  = (state_d == StIdle) || (state_d == StTrst);
    t_re_d = (state_d == StFeed) && (ph_d == 2'd0);
    done_d = (state_d == StDone);
    t_i1_d = '0;
    t_i2_d = '0;
    unique case (state_d)
      StLd0:   begin t_i1_d = ax_d; t_i2_d = ay_d; end
      StLd1:   begin t_i1_d = bx_d; t_i2_d = by_d; end
      StLd2:   begin t_i1_d = cx_d; t_i2_d = cy_d; end
      StFeed:  begin t_i1_d = x_d;  t_i2_d = y_d;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
      xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ph_q   <= 2'd0;
      dcnt_q <= '0;
      busy_q <= 1'b0;
      t_r_q  <= 1'b1;
      t_re_q <= 1'b0;
      t_i1_q <= '0;
      t_i2_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q <= ax_d; ay_q <= ay_d; bx_q <= bx_d; by_q <= by_d; cx_q <= cx_d; cy_q <= cy_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ph_q   <= ph_d;
      dcnt_q <= dcnt_d;
      busy_q <= busy_d;
      t_r_q  <= t_r_d;
      t_re_q <= t_re_d;
      t_i1_q <= t_i1_d;
      t_i2_q <= t_i2_d;
      done_q <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.t_r  = t_r_q;
  assign bus.t_re = t_re_q;
  assign bus.t_i1 = t_i1_q;
  assign bus.t_i2 = t_i2_q;
  assign bus.done = done_q;

  sign_collector #(
    .W        (W),
    .SIGN_LAT (SIGN_LAT)
  ) u_collector (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .strobe_i  (t_re_q),
    .x_i       (t_i1_q),
    .y_i       (t_i2_q),
    .t_s_i     (bus.t_s),
    .p_valid_o (bus.p_valid),
    .px_o      (bus.px),
    .py_o      (bus.py),
    .p_in_o    (bus.p_in)
  );

endmodule

// File: tb/tb_tri_scan_driver.sv
// Directed bench for tri_scan_driver with a behavioural sign tester on the t_* bus.
module tb_tri_scan_driver;
  import tri_scan_pkg::*;

  localparam int unsigned SignLat = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tri_scan_if #(.W(CoordW)) bus ();

  tri_scan_driver #(
    .W        (CoordW),
    .SIGN_LAT (SignLat)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Edge-sign bit: 1 when P lies strictly right of the directed edge U->V.
  function automatic logic sbit(input int ux, uy, vx, vy, qx, qy);
    longint cr;
    cr = longint'(vx - ux) * longint'(qy - uy) - longint'(vy - uy) * longint'(qx - ux);
    return cr < 0;
  endfunction

  function automatic logic exp_in(input int ax, ay, bx, by, cx, cy, qx, qy);
    logic e0, e1, e2;
    e0 = sbit(ax, ay, bx, by, qx, qy);
    e1 = sbit(bx, by, cx, cy, qx, qy);
    e2 = sbit(cx, cy, ax, ay, qx, qy);
    return (e0 == e1) && (e1 == e2);
  endfunction

  // Tester model: vertices captured from the three cycles after t_r falls; the bits of a
  // point appear on t_s SignLat..SignLat+2 cycles after its t_re cycle.
  int   cyc = 0;
  logic sched [64];
  int   vx [3];
  int   vy [3];
  int   ld_idx = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    bus.t_s = sched[cyc % 64];
    sched[cyc % 64] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sched[i] = 1'b0;
      ld_idx = 0;
    end else begin
      if (bus.t_r) begin
        ld_idx = 0;
      end else if (ld_idx < 3) begin
        vx[ld_idx] = int'(bus.t_i1);
        vy[ld_idx] = int'(bus.t_i2);
        ld_idx = ld_idx + 1;
      end
      if (bus.t_re) begin
        sched[(cyc + SignLat) % 64] =
          sbit(vx[0], vy[0], vx[1], vy[1], int'(bus.t_i1), int'(bus.t_i2));
        sched[(cyc + SignLat + 1) % 64] =
          sbit(vx[1], vy[1], vx[2], vy[2], int'(bus.t_i1), int'(bus.t_i2));
        sched[(cyc + SignLat + 2) % 64] =
          sbit(vx[2], vy[2], vx[0], vy[0], int'(bus.t_i1), int'(bus.t_i2));
      end
    end
  end

  // Monitor
  coord_t res_x [$];
  coord_t res_y [$];
  logic   res_in [$];
  int     done_cnt = 0;
  int     busy_cyc = 0;
  int     re_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.p_valid) begin
        res_x.push_back(bus.px);
        res_y.push_back(bus.py);
        res_in.push_back(bus.p_in);
      end
      if (bus.done) done_cnt = done_cnt + 1;
      if (bus.busy) busy_cyc = busy_cyc + 1;
      if (bus.t_re) re_cnt = re_cnt + 1;
    end
  end

  task automatic clear_mon();
    res_x.delete();
    res_y.delete();
    res_in.delete();
    done_cnt = 0;
    busy_cyc = 0;
    re_cnt   = 0;
  endtask

  task automatic start_tri(input int ax, ay, bx, by, cx, cy);
    @(posedge clk);
    #1;
    bus.ax = coord_t'(ax); bus.ay = coord_t'(ay);
    bus.bx = coord_t'(bx); bus.by = coord_t'(by);
    bus.cx = coord_t'(cx); bus.cy = coord_t'(cy);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.t_r !== 1'b1 || bus.busy !== 1'b0 || bus.t_re !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got t_r=%b busy=%b t_re=%b done=%b want 1 0 0 0",
               bus.t_r, bus.busy, bus.t_re, bus.done);
    end
    total++;
    if (bus.t_i1 !== '0 || bus.t_i2 !== '0 || bus.p_valid !== 1'b0 || bus.p_in !== 1'b0 ||
        bus.px !== '0 || bus.py !== '0) begin
      bad++;
      $display("FAIL reset_data: got i1=%0d i2=%0d pv=%b pin=%b px=%0d py=%0d want all 0",
               bus.t_i1, bus.t_i2, bus.p_valid, bus.p_in, bus.px, bus.py);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    repeat (50) @(negedge clk);
    total++;
    if (res_x.size() != 0 || bus.t_r !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: got results=%0d t_r=%b busy=%b want 0 1 0",
               res_x.size(), bus.t_r, bus.busy);
    end
  endtask

  // Runs one triangle and checks the full result stream against the model.
  task automatic test_scan(input string name, input int ax, ay, bx, by, cx, cy, input bit poke);
    bit to;
    int xmin, xmax, ymin, ymax, wx, n, ex, ey;
    logic ein;
    clear_mon();
    start_tri(ax, ay, bx, by, cx, cy);
    if (poke) begin
      for (int i = 0; i < 300 && re_cnt < 3; i++) begin
        @(negedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      bus.ax = 11'd100; bus.ay = 11'd50; bus.bx = 11'd101;
      bus.by = 11'd50;  bus.cx = 11'd100; bus.cy = 11'd52;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    wait_done(to);
    xmin = (ax < bx) ? ax : bx; xmin = (xmin < cx) ? xmin : cx;
    xmax = (ax > bx) ? ax : bx; xmax = (xmax > cx) ? xmax : cx;
    ymin = (ay < by) ? ay : by; ymin = (ymin < cy) ? ymin : cy;
    ymax = (ay > by) ? ay : by; ymax = (ymax > cy) ? ymax : cy;
    wx = xmax - xmin + 1;
    n  = wx * (ymax - ymin + 1);
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s_timeout: got no done within bound want done", name);
    end
    total++;
    if (res_x.size() != n) begin
      bad++;
      $display("FAIL %s_count: got %0d want %0d", name, res_x.size(), n);
    end
    for (int i = 0; i < n && i < res_x.size(); i++) begin
      ex  = xmin + i % wx;
      ey  = ymin + i / wx;
      ein = exp_in(ax, ay, bx, by, cx, cy, ex, ey);
      total++;
      if (res_x[i] !== coord_t'(ex) || res_y[i] !== coord_t'(ey)) begin
        bad++;
        $display("FAIL %s_coord[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 name, i, res_x[i], res_y[i], ex, ey);
      end
      total++;
      if (res_in[i] !== ein) begin
        bad++;
        $display("FAIL %s_p_in(%0d,%0d): got %b want %b", name, ex, ey, res_in[i], ein);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done_count: got %0d want 1", name, done_cnt);
    end
    total++;
    if (busy_cyc != 5 + 3 * n + SignLat + 3) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cyc, 5 + 3 * n + SignLat + 3);
    end
    total++;
    if (re_cnt != n) begin
      bad++;
      $display("FAIL %s_strobes: got %0d want %0d", name, re_cnt, n);
    end
  endtask

  task automatic test_right_tri();
    test_scan("tri", 0, 0, 4, 0, 0, 4, 1'b0);
    total++;
    if (res_in.size() < 25 || res_in[6] !== 1'b1 || res_in[24] !== 1'b0) begin
      bad++;
      $display("FAIL tri_corners: got p_in(1,1)=%b p_in(4,4)=%b want 1 0",
               res_in.size() > 6 ? res_in[6] : 1'bx, res_in.size() > 24 ? res_in[24] : 1'bx);
    end
  endtask

  task automatic test_single_point();
    test_scan("point", 7, 9, 7, 9, 7, 9, 1'b0);
    total++;
    if (res_x.size() != 1 || res_x[0] !== 11'd7 || res_y[0] !== 11'd9 || res_in[0] !== 1'b1) begin
      bad++;
      $display("FAIL point_result: got n=%0d want one inside result at (7,9)", res_x.size());
    end
  endtask

  task automatic test_max_box();
    test_scan("maxbox", 2045, 2045, 2047, 2045, 2045, 2047, 1'b0);
    total++;
    if (res_x.size() != 9 || res_x[3] !== 11'd2045 || res_y[3] !== 11'd2046 ||
        res_x[8] !== 11'd2047 || res_y[8] !== 11'd2047) begin
      bad++;
      $display("FAIL maxbox_wrap: got n=%0d want 9 with (2045,2046) at 3 and (2047,2047) last",
               res_x.size());
    end
    total++;
    if (res_in.size() != 9 || res_in[0] !== 1'b1 || res_in[8] !== 1'b0) begin
      bad++;
      $display("FAIL maxbox_p_in: got n=%0d want first inside, last outside", res_in.size());
    end
  endtask

  task automatic test_start_ignored();
    test_scan("poke", 0, 0, 4, 0, 0, 4, 1'b1);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_tri(0, 0, 4, 0, 0, 4);
    for (int i = 0; i < 300 && re_cnt < 10; i++) begin
      @(negedge clk);
      #1;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.t_r !== 1'b1 || bus.t_re !== 1'b0 || bus.t_i1 !== '0 ||
        bus.t_i2 !== '0 || bus.p_valid !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got busy=%b t_r=%b t_re=%b i1=%0d i2=%0d pv=%b done=%b",
               bus.busy, bus.t_r, bus.t_re, bus.t_i1, bus.t_i2, bus.p_valid, bus.done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    repeat (20) @(negedge clk);
    total++;
    if (res_x.size() != 0 || done_cnt != 0) begin
      bad++;
      $display("FAIL midreset_stale: got results=%0d done=%0d want 0 0", res_x.size(), done_cnt);
    end
    test_scan("after_reset", 0, 0, 4, 0, 0, 4, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ax = '0; bus.ay = '0; bus.bx = '0; bus.by = '0; bus.cx = '0; bus.cy = '0;
    bus.t_s = 1'b0;
    for (int i = 0; i < 64; i++) sched[i] = 1'b0;
    #1;
    test_reset();
    test_right_tri();
    test_single_point();
    test_max_box();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
